// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with a data-memory handshake; define EX_MEM_TIMEOUT_EN to abort stuck accesses.
// Latency: ALU ops 1 edge, memory ops >= 2 edges; stall holds the EX stage while an access is outstanding.
module ex_mem_stage #(
   parameter int N       = 32,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ex_valid,
   input  logic         ex_RegWrite,
   input  logic         ex_MemtoReg,
   input  logic         ex_MemRead,
   input  logic         ex_MemWrite,
   input  logic [N-1:0] ex_AluResult,
   input  logic [N-1:0] ex_WriteData,
   input  logic [N-1:0] ex_PC_4,
   input  logic [4:0]   ex_WriteRegister,
   input  logic         flush,
   output logic         stall,
   output logic         dmem_req,
   output logic         dmem_we,
   output logic [N-1:0] dmem_addr,
   output logic [N-1:0] dmem_wdata,
   input  logic [N-1:0] dmem_rdata,
   input  logic         dmem_ready,
   output logic         wb_valid,
   output logic         wb_RegWrite,
   output logic         wb_MemtoReg,
   output logic         wb_MemRead,
   output logic [N-1:0] wb_ReadData,
   output logic [N-1:0] wb_AluResult,
   output logic [N-1:0] wb_PC_4,
   output logic [4:0]   wb_WriteRegister,
   output logic         mem_err
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t         state_q, state_d;
   logic           req_q, req_d;
   logic           we_q, we_d;
   logic [N-1:0]   addr_q, addr_d;
   logic [N-1:0]   wdata_q, wdata_d;
   logic           lat_regwrite_q, lat_regwrite_d;
   logic           lat_memtoreg_q, lat_memtoreg_d;
   logic           lat_memread_q, lat_memread_d;
   logic [N-1:0]   lat_pc4_q, lat_pc4_d;
   logic [4:0]     lat_wreg_q, lat_wreg_d;
   logic           wb_valid_q, wb_valid_d;
   logic           wb_regwrite_q, wb_regwrite_d;
   logic           wb_memtoreg_q, wb_memtoreg_d;
   logic           wb_memread_q, wb_memread_d;
   logic [N-1:0]   wb_rdata_q, wb_rdata_d;
   logic [N-1:0]   wb_alu_q, wb_alu_d;
   logic [N-1:0]   wb_pc4_q, wb_pc4_d;
   logic [4:0]     wb_wreg_q, wb_wreg_d;
   logic           timeout_hit;

`ifdef EX_MEM_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           err_q, err_d;

   assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
   assign mem_err     = err_q;
`else
   logic           unused_timeout;

   assign unused_timeout = (TIMEOUT == 0);
   assign timeout_hit    = 1'b0;
   assign mem_err        = 1'b0;
`endif

   assign stall = (state_q == S_WAIT);

   always_comb begin
      state_d        = state_q;
      req_d          = req_q;
      we_d           = we_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      lat_regwrite_d = lat_regwrite_q;
      lat_memtoreg_d = lat_memtoreg_q;
      lat_memread_d  = lat_memread_q;
      lat_pc4_d      = lat_pc4_q;
      lat_wreg_d     = lat_wreg_q;
      // Bubble unless a result retires this edge; data buses hold.
      wb_valid_d     = 1'b0;
      wb_regwrite_d  = 1'b0;
      wb_memtoreg_d  = 1'b0;
      wb_memread_d   = 1'b0;
      wb_rdata_d     = wb_rdata_q;
      wb_alu_d       = wb_alu_q;
      wb_pc4_d       = wb_pc4_q;
      wb_wreg_d      = wb_wreg_q;
`ifdef EX_MEM_TIMEOUT_EN
      cnt_d          = cnt_q;
      err_d          = err_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (ex_valid && !flush) begin
               if (ex_MemRead || ex_MemWrite) begin
                  req_d          = 1'b1;
                  we_d           = ex_MemWrite;
                  addr_d         = ex_AluResult;
                  wdata_d        = ex_WriteData;
                  lat_regwrite_d = ex_RegWrite;
                  lat_memtoreg_d = ex_MemtoReg;
                  // A read+write pair is executed as a plain write.
                  lat_memread_d  = ex_MemRead && !ex_MemWrite;
                  lat_pc4_d      = ex_PC_4;
                  lat_wreg_d     = ex_WriteRegister;
                  state_d        = S_WAIT;
`ifdef EX_MEM_TIMEOUT_EN
                  cnt_d          = '0;
`endif
               end else begin
                  wb_valid_d    = 1'b1;
                  wb_regwrite_d = ex_RegWrite;
                  wb_memtoreg_d = ex_MemtoReg;
                  wb_memread_d  = 1'b0;
                  wb_rdata_d    = '0;
                  wb_alu_d      = ex_AluResult;
                  wb_pc4_d      = ex_PC_4;
                  wb_wreg_d     = ex_WriteRegister;
               end
            end
         end
         S_WAIT: begin
            if (dmem_ready) begin
               req_d         = 1'b0;
               wb_valid_d    = 1'b1;
               wb_regwrite_d = lat_regwrite_q;
               wb_memtoreg_d = lat_memtoreg_q;
               wb_memread_d  = lat_memread_q;
               wb_rdata_d    = lat_memread_q ? dmem_rdata : '0;
               wb_alu_d      = addr_q;
               wb_pc4_d      = lat_pc4_q;
               wb_wreg_d     = lat_wreg_q;
               state_d       = S_IDLE;
            end else if (timeout_hit) begin
               req_d   = 1'b0;
               state_d = S_IDLE;
`ifdef EX_MEM_TIMEOUT_EN
               err_d   = 1'b1;
               cnt_d   = '0;
`endif
            end else begin
`ifdef EX_MEM_TIMEOUT_EN
               cnt_d = cnt_q + CW'(1);
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         req_q          <= 1'b0;
         we_q           <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         lat_regwrite_q <= 1'b0;
         lat_memtoreg_q <= 1'b0;
         lat_memread_q  <= 1'b0;
         lat_pc4_q      <= '0;
         lat_wreg_q     <= '0;
         wb_valid_q     <= 1'b0;
         wb_regwrite_q  <= 1'b0;
         wb_memtoreg_q  <= 1'b0;
         wb_memread_q   <= 1'b0;
         wb_rdata_q     <= '0;
         wb_alu_q       <= '0;
         wb_pc4_q       <= '0;
         wb_wreg_q      <= '0;
      end else begin
         state_q        <= state_d;
         req_q          <= req_d;
         we_q           <= we_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         lat_regwrite_q <= lat_regwrite_d;
         lat_memtoreg_q <= lat_memtoreg_d;
         lat_memread_q  <= lat_memread_d;
         lat_pc4_q      <= lat_pc4_d;
         lat_wreg_q     <= lat_wreg_d;
         wb_valid_q     <= wb_valid_d;
         wb_regwrite_q  <= wb_regwrite_d;
         wb_memtoreg_q  <= wb_memtoreg_d;
         wb_memread_q   <= wb_memread_d;
         wb_rdata_q     <= wb_rdata_d;
         wb_alu_q       <= wb_alu_d;
         wb_pc4_q       <= wb_pc4_d;
         wb_wreg_q      <= wb_wreg_d;
      end
   end

`ifdef EX_MEM_TIMEOUT_EN
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
`endif

   assign dmem_req         = req_q;
   assign dmem_we          = we_q;
   assign dmem_addr        = addr_q;
   assign dmem_wdata       = wdata_q;
   assign wb_valid         = wb_valid_q;
   assign wb_RegWrite      = wb_regwrite_q;
   assign wb_MemtoReg      = wb_memtoreg_q;
   assign wb_MemRead       = wb_memread_q;
   assign wb_ReadData      = wb_rdata_q;
   assign wb_AluResult     = wb_alu_q;
   assign wb_PC_4          = wb_pc4_q;
   assign wb_WriteRegister = wb_wreg_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: inputs change on the rising edge, the DUT acts on the falling edge,
// outputs are sampled on the following rising edge.
module tb_ex_mem_stage;
   localparam int N = 32;
   localparam int TO = 16;

   logic         clk, reset;
   logic         ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, flush;
   logic [N-1:0] ex_AluResult, ex_WriteData, ex_PC_4;
   logic [4:0]   ex_WriteRegister;
   logic         stall, dmem_req, dmem_we, dmem_ready;
   logic [N-1:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic         wb_valid, wb_RegWrite, wb_MemtoReg, wb_MemRead, mem_err;
   logic [N-1:0] wb_ReadData, wb_AluResult, wb_PC_4;
   logic [4:0]   wb_WriteRegister;

   int total = 0;
   int bad = 0;

   ex_mem_stage #(.N(N), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg),
      .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
      .ex_AluResult(ex_AluResult), .ex_WriteData(ex_WriteData), .ex_PC_4(ex_PC_4),
      .ex_WriteRegister(ex_WriteRegister), .flush(flush), .stall(stall),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
      .wb_MemRead(wb_MemRead), .wb_ReadData(wb_ReadData), .wb_AluResult(wb_AluResult),
      .wb_PC_4(wb_PC_4), .wb_WriteRegister(wb_WriteRegister), .mem_err(mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Let one falling (active) edge pass, then return on the next rising edge.
   task automatic cyc();
      @(negedge clk);
      @(posedge clk);
   endtask

   task automatic drive(input logic v, input logic rw, input logic m2r, input logic mr, input logic mw,
                        input logic [N-1:0] alu, input logic [N-1:0] wd, input logic [N-1:0] pc4,
                        input logic [4:0] wreg, input logic fl);
      ex_valid = v; ex_RegWrite = rw; ex_MemtoReg = m2r; ex_MemRead = mr; ex_MemWrite = mw;
      ex_AluResult = alu; ex_WriteData = wd; ex_PC_4 = pc4; ex_WriteRegister = wreg; flush = fl;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 5'd0, 1'b0);
      dmem_ready = 1'b0; dmem_rdata = '0;
      repeat (2) cyc();
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%0h exp=0", wb_valid); end
      total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL rst_dmem_req got=%0h exp=0", dmem_req); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", stall); end
      total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL rst_mem_err got=%0h exp=0", mem_err); end
      total++; if ({wb_AluResult, wb_ReadData, dmem_addr} !== 96'd0) begin bad++;
         $display("FAIL rst_buses got=%0h exp=0", {wb_AluResult, wb_ReadData, dmem_addr}); end
      reset = 1'b1;
   endtask

   task automatic test_alu_op();
      int stall_seen = 0;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h104, 5'd5, 1'b0);
      if (stall !== 1'b0) stall_seen++;
      cyc();
      if (stall !== 1'b0) stall_seen++;
      total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL alu_valid got=%0h exp=1", wb_valid); end
      total++; if (wb_AluResult !== 32'h10) begin bad++; $display("FAIL alu_result got=%0h exp=10", wb_AluResult); end
      total++; if (wb_WriteRegister !== 5'd5) begin bad++; $display("FAIL alu_wreg got=%0d exp=5", wb_WriteRegister); end
      total++; if ({wb_RegWrite, wb_MemtoReg, wb_MemRead} !== 3'b100) begin bad++;
         $display("FAIL alu_ctrl got=%b exp=100", {wb_RegWrite, wb_MemtoReg, wb_MemRead}); end
      total++; if (wb_PC_4 !== 32'h104 || wb_ReadData !== 32'h0) begin bad++;
         $display("FAIL alu_pc_rdata got=%0h/%0h exp=104/0", wb_PC_4, wb_ReadData); end
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 32'h0, 5'd9, 1'b0);
      cyc();
      if (stall !== 1'b0) stall_seen++;
      total++; if ({wb_valid, wb_RegWrite, wb_MemtoReg, wb_MemRead} !== 4'b0000) begin bad++;
         $display("FAIL bubble_ctrl got=%b exp=0000", {wb_valid, wb_RegWrite, wb_MemtoReg, wb_MemRead}); end
      total++; if (wb_AluResult !== 32'h10 || wb_WriteRegister !== 5'd5) begin bad++;
         $display("FAIL bubble_hold got=%0h/%0d exp=10/5", wb_AluResult, wb_WriteRegister); end
      total++; if (stall_seen !== 0) begin bad++; $display("FAIL alu_stall got=%0d exp=0", stall_seen); end
   endtask

   task automatic test_load();
      int stall_cnt = 0;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 32'h200, 5'd7, 1'b0);
      dmem_ready = 1'b0;
      cyc();
      if (stall === 1'b1) stall_cnt++;
      total++; if ({dmem_req, dmem_we} !== 2'b10 || dmem_addr !== 32'h40) begin bad++;
         $display("FAIL load_req got=%b addr=%0h exp=10 addr=40", {dmem_req, dmem_we}, dmem_addr); end
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL load_bubble got=%0h exp=0", wb_valid); end
      // Conflicting EX traffic while waiting must be ignored.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h999, 32'h0, 32'h0, 5'd3, 1'b0);
      for (int i = 0; i < 2; i++) begin
         cyc();
         if (stall === 1'b1) stall_cnt++;
         total++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h40 || wb_valid !== 1'b0) begin bad++;
            $display("FAIL load_hold%0d got=req%0h addr%0h v%0h exp=req1 addr40 v0", i, dmem_req, dmem_addr, wb_valid); end
      end
      dmem_ready = 1'b1; dmem_rdata = 32'hCAFEF00D;
      cyc();
      total++; if (stall_cnt !== 3) begin bad++; $display("FAIL load_stall_cycles got=%0d exp=3", stall_cnt); end
      total++; if (wb_valid !== 1'b1 || wb_ReadData !== 32'hCAFEF00D) begin bad++;
         $display("FAIL load_done got=v%0h rd%0h exp=v1 rdCAFEF00D", wb_valid, wb_ReadData); end
      total++; if ({wb_RegWrite, wb_MemtoReg, wb_MemRead} !== 3'b111 || wb_WriteRegister !== 5'd7 || wb_AluResult !== 32'h40) begin bad++;
         $display("FAIL load_fields got=%b wr%0d alu%0h exp=111 wr7 alu40", {wb_RegWrite, wb_MemtoReg, wb_MemRead}, wb_WriteRegister, wb_AluResult); end
      total++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin bad++;
         $display("FAIL load_release got=req%0h stall%0h exp=0/0", dmem_req, stall); end
      dmem_ready = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 5'd0, 1'b0);
      cyc();
      total++; if (wb_valid !== 1'b0 || wb_ReadData !== 32'hCAFEF00D) begin bad++;
         $display("FAIL load_pulse got=v%0h rd%0h exp=v0 rdCAFEF00D", wb_valid, wb_ReadData); end
   endtask

   task automatic test_store();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'h12345678, 32'h300, 5'd0, 1'b0);
      cyc();
      total++; if ({dmem_req, dmem_we} !== 2'b11 || dmem_addr !== 32'h80 || dmem_wdata !== 32'h12345678) begin bad++;
         $display("FAIL store_req got=%b a%0h d%0h exp=11 a80 d12345678", {dmem_req, dmem_we}, dmem_addr, dmem_wdata); end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 5'd0, 1'b0);
      dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF;
      cyc();
      total++; if (wb_valid !== 1'b1 || wb_RegWrite !== 1'b0 || wb_ReadData !== 32'h0) begin bad++;
         $display("FAIL store_done got=v%0h rw%0h rd%0h exp=v1 rw0 rd0", wb_valid, wb_RegWrite, wb_ReadData); end
      // Read and write together behave as a write.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h84, 32'h55, 32'h304, 5'd2, 1'b0);
      dmem_ready = 1'b0;
      cyc();
      total++; if ({dmem_req, dmem_we} !== 2'b11) begin bad++; $display("FAIL rw_req got=%b exp=11", {dmem_req, dmem_we}); end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 5'd0, 1'b0);
      dmem_ready = 1'b1; dmem_rdata = 32'hFFFF;
      cyc();
      total++; if (wb_valid !== 1'b1 || wb_MemRead !== 1'b0 || wb_ReadData !== 32'h0) begin bad++;
         $display("FAIL rw_done got=v%0h mr%0h rd%0h exp=v1 mr0 rd0", wb_valid, wb_MemRead, wb_ReadData); end
      dmem_ready = 1'b0;
   endtask

   task automatic test_flush();
      // Flushed load in IDLE, with a stray dmem_ready that must be ignored.
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 32'h400, 5'd4, 1'b1);
      dmem_ready = 1'b1; dmem_rdata = 32'hBAD;
      cyc();
      total++; if (dmem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0) begin bad++;
         $display("FAIL flush_idle got=req%0h st%0h v%0h exp=0/0/0", dmem_req, stall, wb_valid); end
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 32'h400, 5'd4, 1'b0);
      dmem_ready = 1'b0;
      cyc();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 5'd0, 1'b1);
      cyc();
      total++; if (dmem_req !== 1'b1 || stall !== 1'b1) begin bad++;
         $display("FAIL flush_wait got=req%0h st%0h exp=1/1", dmem_req, stall); end
      dmem_ready = 1'b1; dmem_rdata = 32'h11112222;
      cyc();
      total++; if (wb_valid !== 1'b1 || wb_ReadData !== 32'h11112222 || wb_WriteRegister !== 5'd4) begin bad++;
         $display("FAIL flush_complete got=v%0h rd%0h wr%0d exp=v1 rd11112222 wr4", wb_valid, wb_ReadData, wb_WriteRegister); end
      dmem_ready = 1'b0; flush = 1'b0;
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA1, 32'h0, 32'h500, 5'd10, 1'b0);
      cyc();
      total++; if (wb_valid !== 1'b1 || wb_AluResult !== 32'hA1) begin bad++;
         $display("FAIL b2b_first got=v%0h a%0h exp=v1 aA1", wb_valid, wb_AluResult); end
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hB2, 32'h0, 32'h504, 5'd11, 1'b0);
      cyc();
      total++; if (wb_valid !== 1'b1 || wb_AluResult !== 32'hB2 || {wb_RegWrite, wb_MemtoReg} !== 2'b01) begin bad++;
         $display("FAIL b2b_second got=v%0h a%0h c%b exp=v1 aB2 c01", wb_valid, wb_AluResult, {wb_RegWrite, wb_MemtoReg}); end
   endtask

   task automatic test_reset_mid_wait();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h48, 32'h0, 32'h600, 5'd6, 1'b0);
      cyc();
      total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL rmw_req got=%0h exp=1", dmem_req); end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 5'd0, 1'b0);
      reset = 1'b0;
      #1;
      total++; if ({dmem_req, dmem_we, stall, wb_valid} !== 4'b0000 || dmem_addr !== 32'h0 || wb_AluResult !== 32'h0) begin bad++;
         $display("FAIL rmw_immediate got=%b a%0h w%0h exp=0000 a0 w0", {dmem_req, dmem_we, stall, wb_valid}, dmem_addr, wb_AluResult); end
      dmem_ready = 1'b1; dmem_rdata = 32'h5A5A;
      cyc();
      reset = 1'b1;
      cyc();
      total++; if (wb_valid !== 1'b0 || stall !== 1'b0 || dmem_req !== 1'b0) begin bad++;
         $display("FAIL rmw_no_pulse got=v%0h st%0h req%0h exp=0/0/0", wb_valid, stall, dmem_req); end
      dmem_ready = 1'b0;
   endtask

   task automatic test_timeout();
      int stall_cnt = 0;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h4C, 32'h0, 32'h700, 5'd8, 1'b0);
      dmem_ready = 1'b0;
      cyc();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 5'd0, 1'b0);
`ifdef EX_MEM_TIMEOUT_EN
      if (stall === 1'b1) stall_cnt++;
      for (int i = 0; i < 40 && stall === 1'b1; i++) begin
         cyc();
         if (stall === 1'b1) stall_cnt++;
      end
      total++; if (stall_cnt !== TO) begin bad++; $display("FAIL to_wait_cycles got=%0d exp=%0d", stall_cnt, TO); end
      total++; if (dmem_req !== 1'b0 || mem_err !== 1'b1 || wb_valid !== 1'b0) begin bad++;
         $display("FAIL to_abort got=req%0h err%0h v%0h exp=0/1/0", dmem_req, mem_err, wb_valid); end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hC3, 32'h0, 32'h800, 5'd12, 1'b0);
      cyc();
      total++; if (wb_valid !== 1'b1 || wb_AluResult !== 32'hC3 || mem_err !== 1'b1) begin bad++;
         $display("FAIL to_next got=v%0h a%0h err%0h exp=v1 aC3 err1", wb_valid, wb_AluResult, mem_err); end
`else
      for (int i = 0; i < 3 * TO; i++) begin
         if (stall === 1'b1 && dmem_req === 1'b1 && mem_err === 1'b0) stall_cnt++;
         cyc();
      end
      total++; if (stall_cnt !== 3 * TO) begin bad++; $display("FAIL nto_persist got=%0d exp=%0d", stall_cnt, 3 * TO); end
      dmem_ready = 1'b1; dmem_rdata = 32'h600D;
      cyc();
      total++; if (wb_valid !== 1'b1 || wb_ReadData !== 32'h600D || mem_err !== 1'b0) begin bad++;
         $display("FAIL nto_complete got=v%0h rd%0h err%0h exp=v1 rd600D err0", wb_valid, wb_ReadData, mem_err); end
      dmem_ready = 1'b0;
`endif
   endtask

   initial begin
      test_reset();
      test_alu_op();
      test_load();
      test_store();
      test_flush();
      test_back_to_back();
      test_reset_mid_wait();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
